// File: rtl/pipe_out_block_fifo.sv
// Block-buffered source stage feeding the okBTPipeOut endpoint.
// A producer pushes 16-bit words into a FIFO. pipe_out_ready is raised only
// when a whole block is buffered and no burst is running. A small FSM tracks
// each burst. Saturating counters record overflow, underflow and protocol
// errors.
module pipe_out_block_fifo #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned AW          = 10,
  parameter int unsigned BLOCK_WORDS = 256
) (
  input  logic          ti_clk,
  input  logic          reset,
  input  logic          src_write,
  input  logic [15:0]   src_data,
  output logic          src_full,
  input  logic          pipe_out_blockstrobe,
  input  logic          pipe_out_read,
  output logic [15:0]   pipe_out_data,
  output logic          pipe_out_ready,
  output logic [AW:0]   fifo_level,
  output logic [15:0]   overflow_count,
  output logic [15:0]   underflow_count,
  output logic [15:0]   protocol_errors
);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  localparam logic [AW:0] DepthW = (AW+1)'(DEPTH);
  localparam logic [AW:0] BlockW = (AW+1)'(BLOCK_WORDS);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q, level_d;
  logic [15:0]   data_q;
  state_e        state_q, state_d;
  logic [AW:0]   words_left_q, words_left_d;
  logic          ready_q, ready_d;
  logic          full_q, full_d;
  logic [15:0]   of_q, uf_q, pe_q;

  logic is_full, is_empty, wr_ok, rd_ok, of_inc, uf_inc, pe_inc;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic inc);
    return (inc && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

  // Accept/pop decisions and level bookkeeping; full check uses the start-of-cycle level.
  always_comb begin
    is_full  = (level_q == DepthW);
    is_empty = (level_q == '0);
    wr_ok    = src_write & ~is_full;
    rd_ok    = pipe_out_read & ~is_empty;
    of_inc   = src_write & is_full;
    uf_inc   = pipe_out_read & is_empty;
    level_d  = level_q;
    if (wr_ok && !rd_ok) begin
      level_d = level_q + 1'b1;
    end else if (!wr_ok && rd_ok) begin
      level_d = level_q - 1'b1;
    end
  end

  // Burst FSM; underflowing reads still consume a burst slot.
  always_comb begin
    state_d      = state_q;
    words_left_d = words_left_q;
    pe_inc       = 1'b0;
    case (state_q)
      StIdle: begin
        if (pipe_out_blockstrobe) begin
          // A read alongside the strobe counts as the first word of the burst.
          words_left_d = pipe_out_read ? BlockW - 1'b1 : BlockW;
          state_d      = (words_left_d == '0) ? StIdle : StBurst;
        end else if (pipe_out_read) begin
          pe_inc = 1'b1;
        end
      end
      StBurst: begin
        if (pipe_out_blockstrobe) begin
          pe_inc = 1'b1;
        end
        if (pipe_out_read) begin
          words_left_d = words_left_q - 1'b1;
          if (words_left_q == (AW+1)'(1)) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    ready_d = (state_d == StIdle) && (level_d >= BlockW);
    full_d  = (level_d == DepthW);
  end

  // Storage array; no reset needed since contents are only read when valid.
  always_ff @(posedge ti_clk) begin
    if (!reset && wr_ok) begin
      mem[wr_ptr_q] <= src_data;
    end
  end

  // Control, output and counter registers with synchronous reset.
  always_ff @(posedge ti_clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      data_q       <= '0;
      state_q      <= StIdle;
      words_left_q <= '0;
      ready_q      <= 1'b0;
      full_q       <= 1'b0;
      of_q         <= '0;
      uf_q         <= '0;
      pe_q         <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        data_q   <= mem[rd_ptr_q];
      end
      level_q      <= level_d;
      state_q      <= state_d;
      words_left_q <= words_left_d;
      ready_q      <= ready_d;
      full_q       <= full_d;
      of_q         <= sat_inc(of_q, of_inc);
      uf_q         <= sat_inc(uf_q, uf_inc);
      pe_q         <= sat_inc(pe_q, pe_inc);
    end
  end

  assign src_full        = full_q;
  assign pipe_out_data   = data_q;
  assign pipe_out_ready  = ready_q;
  assign fifo_level      = level_q;
  assign overflow_count  = of_q;
  assign underflow_count = uf_q;
  assign protocol_errors = pe_q;

endmodule

// File: tb/tb_pipe_out_block_fifo.sv
// Directed bench for pipe_out_block_fifo: a cycle table for the basic
// pop/underflow/protocol behaviour, then hand-written burst sequences.
module tb_pipe_out_block_fifo;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned AW    = 10;
  localparam int unsigned BLK   = 256;

  logic          ti_clk = 1'b0;
  logic          reset = 1'b0;
  logic          src_write = 1'b0;
  logic [15:0]   src_data = '0;
  logic          src_full;
  logic          pipe_out_blockstrobe = 1'b0;
  logic          pipe_out_read = 1'b0;
  logic [15:0]   pipe_out_data;
  logic          pipe_out_ready;
  logic [AW:0]   fifo_level;
  logic [15:0]   overflow_count;
  logic [15:0]   underflow_count;
  logic [15:0]   protocol_errors;

  int total = 0;
  int bad   = 0;

  pipe_out_block_fifo #(
    .DEPTH      (DEPTH),
    .AW         (AW),
    .BLOCK_WORDS(BLK)
  ) dut (
    .ti_clk              (ti_clk),
    .reset               (reset),
    .src_write           (src_write),
    .src_data            (src_data),
    .src_full            (src_full),
    .pipe_out_blockstrobe(pipe_out_blockstrobe),
    .pipe_out_read       (pipe_out_read),
    .pipe_out_data       (pipe_out_data),
    .pipe_out_ready      (pipe_out_ready),
    .fifo_level          (fifo_level),
    .overflow_count      (overflow_count),
    .underflow_count     (underflow_count),
    .protocol_errors     (protocol_errors)
  );

  always #5 ti_clk = ~ti_clk;

  typedef struct {
    logic        rst;
    logic        wr;
    logic [15:0] din;
    logic        stb;
    logic        rd;
    int          lvl;
    logic [15:0] dout;
    logic        rdy;
    int          uf;
    int          of;
    int          pe;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Apply one cycle of inputs, sample 1 ns after the edge, then return inputs to idle.
  task automatic cyc(input logic r, input logic w, input logic [15:0] d,
                     input logic s, input logic rd);
    reset = r; src_write = w; src_data = d;
    pipe_out_blockstrobe = s; pipe_out_read = rd;
    @(posedge ti_clk);
    #1;
    reset = 1'b0; src_write = 1'b0; src_data = '0;
    pipe_out_blockstrobe = 1'b0; pipe_out_read = 1'b0;
  endtask

  task automatic burst_read(input string name, input int base);
    cyc(0, 0, 16'h0, 1, 0);
    chk({name, " ready low on strobe"}, int'(pipe_out_ready), 0);
    for (int i = 0; i < int'(BLK); i++) begin
      cyc(0, 0, 16'h0, 0, 1);
      chk({name, " data"}, int'(pipe_out_data), (base + i) & 16'hFFFF);
      if (i < int'(BLK) - 1) chk({name, " ready in burst"}, int'(pipe_out_ready), 0);
    end
    chk({name, " state idle after burst"}, int'(dut.state_q), 0);
  endtask

  initial begin
    //          rst wr din       stb rd  lvl dout      rdy uf of pe
    vecs[0]  = '{1, 0, 16'h0000, 0, 0,  0, 16'h0000, 0, 0, 0, 0};
    vecs[1]  = '{0, 1, 16'h1111, 0, 0,  1, 16'h0000, 0, 0, 0, 0};
    vecs[2]  = '{0, 1, 16'h2222, 0, 0,  2, 16'h0000, 0, 0, 0, 0};
    vecs[3]  = '{0, 0, 16'h0000, 0, 1,  1, 16'h1111, 0, 0, 0, 1};
    vecs[4]  = '{0, 1, 16'h3333, 0, 1,  1, 16'h2222, 0, 0, 0, 2};
    vecs[5]  = '{0, 0, 16'h0000, 0, 1,  0, 16'h3333, 0, 0, 0, 3};
    vecs[6]  = '{0, 0, 16'h0000, 0, 1,  0, 16'h3333, 0, 1, 0, 4};
    vecs[7]  = '{0, 1, 16'h4444, 0, 1,  1, 16'h3333, 0, 2, 0, 5};
    vecs[8]  = '{0, 0, 16'h0000, 1, 0,  1, 16'h3333, 0, 2, 0, 5};
    vecs[9]  = '{0, 0, 16'h0000, 1, 1,  0, 16'h4444, 0, 2, 0, 6};
    vecs[10] = '{1, 0, 16'h0000, 0, 0,  0, 16'h0000, 0, 0, 0, 0};

    for (int v = 0; v < 11; v++) begin
      cyc(vecs[v].rst, vecs[v].wr, vecs[v].din, vecs[v].stb, vecs[v].rd);
      chk($sformatf("vec%0d level", v), int'(fifo_level), vecs[v].lvl);
      chk($sformatf("vec%0d data", v), int'(pipe_out_data), int'(vecs[v].dout));
      chk($sformatf("vec%0d ready", v), int'(pipe_out_ready), int'(vecs[v].rdy));
      chk($sformatf("vec%0d underflow", v), int'(underflow_count), vecs[v].uf);
      chk($sformatf("vec%0d overflow", v), int'(overflow_count), vecs[v].of);
      chk($sformatf("vec%0d protocol", v), int'(protocol_errors), vecs[v].pe);
    end
    chk("vec9 words_left", int'(dut.words_left_q), 0);

    // One word short of a block, then the completing word.
    for (int i = 0; i < 255; i++) cyc(0, 1, 16'(i), 0, 0);
    chk("a ready at 255", int'(pipe_out_ready), 0);
    chk("a level 255", int'(fifo_level), 255);
    cyc(0, 1, 16'd255, 0, 0);
    chk("a ready at 256", int'(pipe_out_ready), 1);
    chk("a level 256", int'(fifo_level), 256);

    burst_read("b", 0);
    chk("b level", int'(fifo_level), 0);
    chk("b ready after", int'(pipe_out_ready), 0);
    chk("b underflow", int'(underflow_count), 0);
    chk("b overflow", int'(overflow_count), 0);
    chk("b protocol", int'(protocol_errors), 0);

    // Underflowing read in a burst keeps the last word.
    cyc(0, 0, 16'h0, 1, 0);
    cyc(0, 0, 16'h0, 0, 1);
    chk("d underflow", int'(underflow_count), 1);
    chk("d data held", int'(pipe_out_data), 16'h00FF);
    chk("d words_left", int'(dut.words_left_q), 255);
    for (int i = 0; i < 255; i++) cyc(0, 0, 16'h0, 0, 1);
    chk("d state idle", int'(dut.state_q), 0);
    chk("d underflow total", int'(underflow_count), 256);
    cyc(0, 0, 16'h0, 0, 1);
    chk("d protocol idle read", int'(protocol_errors), 1);

    // Fill to full, overflow once, drain in four bursts.
    cyc(1, 0, 16'h0, 0, 0);
    for (int i = 0; i < int'(DEPTH); i++) cyc(0, 1, 16'(i), 0, 0);
    chk("c full", int'(src_full), 1);
    chk("c level full", int'(fifo_level), 1024);
    chk("c ready", int'(pipe_out_ready), 1);
    cyc(0, 1, 16'hBEEF, 0, 0);
    chk("c overflow", int'(overflow_count), 1);
    chk("c level kept", int'(fifo_level), 1024);
    chk("c full kept", int'(src_full), 1);
    for (int b = 0; b < 4; b++) burst_read("c", b * int'(BLK));
    chk("c level drained", int'(fifo_level), 0);
    chk("c full cleared", int'(src_full), 0);
    chk("c overflow kept", int'(overflow_count), 1);
    chk("c protocol", int'(protocol_errors), 0);

    // Streaming writes and reads together inside a burst at level 300.
    cyc(1, 0, 16'h0, 0, 0);
    for (int i = 0; i < 300; i++) cyc(0, 1, 16'(i), 0, 0);
    chk("e ready", int'(pipe_out_ready), 1);
    cyc(0, 0, 16'h0, 1, 0);
    chk("e ready low", int'(pipe_out_ready), 0);
    for (int k = 0; k < 50; k++) begin
      cyc(0, 1, 16'(300 + k), 0, 1);
      chk("e data order", int'(pipe_out_data), k);
      chk("e level steady", int'(fifo_level), 300);
    end
    cyc(0, 0, 16'h0, 1, 0);
    chk("e strobe in burst", int'(protocol_errors), 1);
    chk("e words_left", int'(dut.words_left_q), 206);
    for (int k = 50; k < 100; k++) begin
      cyc(0, 0, 16'h0, 0, 1);
      chk("e data", int'(pipe_out_data), k);
    end

    // Reset mid-burst.
    cyc(1, 0, 16'h0, 0, 0);
    chk("f level", int'(fifo_level), 0);
    chk("f data", int'(pipe_out_data), 0);
    chk("f ready", int'(pipe_out_ready), 0);
    chk("f full", int'(src_full), 0);
    chk("f protocol", int'(protocol_errors), 0);
    chk("f underflow", int'(underflow_count), 0);
    chk("f overflow", int'(overflow_count), 0);
    chk("f state", int'(dut.state_q), 0);
    for (int i = 0; i < int'(BLK); i++) cyc(0, 1, 16'(16'hA000 + i), 0, 0);
    chk("f ready refill", int'(pipe_out_ready), 1);
    burst_read("f", 16'hA000);
    chk("f level end", int'(fifo_level), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
